alu_mdu_seq: RTL and testbench

- Parametrised, registered successor to the datapath ALU, with a multi-cycle multiply/divide unit (MDU) and architectural HI/LO registers.
- Sits in the EX stage of the MIPS core.
- Single-cycle ops return a registered result one cycle after issue. MULT/DIV ops iterate over WIDTH cycles, and the pipeline sees a busy/ready handshake while they run.

---
 rtl/alu_mdu_seq_if.sv | 29 ++
 rtl/alu_mdu_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_mdu_seq.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_seq_if.sv
// Issue/result bundle between the EX-stage control and the ALU/MDU.
// The master side issues operations; the slave side returns results and HI/LO.
interface alu_mdu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             InValid;
    logic             InReady;
    logic             Flush;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             OutValid;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Overflow;
    logic             Busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output InValid, Flush, ALUControl, A, B,
        input  InReady, OutValid, ALUResult, Zero, Overflow, Busy, HI, LO
    );

    modport slave (
        input  InValid, Flush, ALUControl, A, B,
        output InReady, OutValid, ALUResult, Zero, Overflow, Busy, HI, LO
    );
endinterface

// File: rtl/alu_mdu_seq.sv
// Registered EX-stage ALU with an iterative multiply/divide unit and HI/LO.
// Single-cycle ops answer on the next cycle; MDU ops take WIDTH+2 cycles.
module alu_mdu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic            Clk,
    input  logic            Rst_n,
    alu_mdu_seq_if.slave    bus
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_MFHI = 4'd13;
    localparam logic [3:0] OP_MFLO = 4'd14;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               div0_q, div0_d;
    logic               isdiv_q, isdiv_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               ovalid_q, ovalid_d;

    logic               accept;
    logic               is_mdu;
    logic               sgn_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   sum, diff;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_ovf;
    logic [WIDTH:0]     mstep;
    logic [WIDTH:0]     shifted;
    logic               qbit;
    logic [2*WIDTH-1:0] prod;

    assign accept = bus.InValid && !bus.Flush && (state_q == S_IDLE);
    assign is_mdu = (bus.ALUControl[3:2] == 2'b10);
    assign sgn_op = !bus.ALUControl[0];
    assign a_neg  = sgn_op && bus.A[WIDTH-1];
    assign b_neg  = sgn_op && bus.B[WIDTH-1];
    assign mag_a  = a_neg ? -bus.A : bus.A;
    assign mag_b  = b_neg ? -bus.B : bus.B;

    assign sum  = bus.A + bus.B;
    assign diff = bus.A - bus.B;

    // Multiply keeps {acc, mq} as the partial product, multiplier shifting out of mq.
    assign mstep   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
    // Divide shifts the dividend out of mq's MSB while quotient bits enter at the LSB.
    assign shifted = {acc_q, mq_q[WIDTH-1]};
    assign qbit    = (shifted >= {1'b0, opb_q});
    assign prod    = {acc_q, mq_q};

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (bus.ALUControl)
            OP_AND:  sc_res = bus.A & bus.B;
            OP_OR:   sc_res = bus.A | bus.B;
            OP_XOR:  sc_res = bus.A ^ bus.B;
            OP_NOR:  sc_res = ~(bus.A | bus.B);
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SLT:  sc_res = WIDTH'($signed(bus.A) < $signed(bus.B));
            OP_SLTU: sc_res = WIDTH'(bus.A < bus.B);
            OP_MFHI: sc_res = hi_q;
            OP_MFLO: sc_res = lo_q;
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        opb_d    = opb_q;
        dvd_d    = dvd_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        isdiv_d  = isdiv_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_d    = res_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ovalid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mdu) begin
                    state_d = bus.ALUControl[1] ? S_DIV : S_MUL;
                    cnt_d   = '0;
                    acc_d   = '0;
                    mq_d    = mag_a;
                    opb_d   = mag_b;
                    dvd_d   = bus.A;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    div0_d  = (bus.B == '0);
                    isdiv_d = bus.ALUControl[1];
                end else if (accept) begin
                    res_d    = sc_res;
                    zero_d   = (sc_res == '0);
                    ovf_d    = sc_ovf;
                    ovalid_d = 1'b1;
                end
            end
            S_MUL: begin
                if (bus.Flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = mstep[WIDTH:1];
                    mq_d  = {mstep[0], mq_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_DIV: begin
                if (bus.Flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = WIDTH'(qbit ? (shifted - {1'b0, opb_q}) : shifted);
                    mq_d  = {mq_q[WIDTH-2:0], qbit};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (bus.Flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (!isdiv_q) begin
                        {acc_d, mq_d} = neg_q ? -prod : prod;
                    end else if (div0_q) begin
                        mq_d  = '1;
                        acc_d = dvd_q;
                    end else begin
                        if (neg_q)  mq_d  = -mq_q;
                        if (rneg_q) acc_d = -acc_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!bus.Flush) begin
                    hi_d     = acc_q;
                    lo_d     = mq_q;
                    res_d    = mq_q;
                    zero_d   = (mq_q == '0);
                    ovf_d    = 1'b0;
                    ovalid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            opb_q    <= '0;
            dvd_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            isdiv_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opb_q    <= opb_d;
            dvd_q    <= dvd_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            isdiv_q  <= isdiv_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign bus.InReady   = (state_q == S_IDLE);
    assign bus.Busy      = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign bus.OutValid  = ovalid_q;
    assign bus.ALUResult = res_q;
    assign bus.Zero      = zero_q;
    assign bus.Overflow  = ovf_q;
    assign bus.HI        = hi_q;
    assign bus.LO        = lo_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Randomised bench for alu_mdu_seq against an arithmetic reference model.
// Covers single-cycle ops, MDU latency and results, flush and async reset.
module tb_alu_mdu_seq;

    logic Clk;
    logic Rst_n;
    int   n_cmp;
    int   n_err;
    logic [31:0] hi_m, lo_m, res_m;

    alu_mdu_seq_if #(.WIDTH(32)) bus ();

    alu_mdu_seq #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Returns {overflow, result} for single-cycle opcodes.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        logic [31:0] r;
        logic v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        v = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd4:  r = a ^ b;
            4'd12: r = ~(a | b);
            4'd2: begin
                s = sa + sb;
                r = s[31:0];
                v = (s != longint'($signed(r)));
            end
            4'd6: begin
                s = sa - sb;
                r = s[31:0];
                v = (s != longint'($signed(r)));
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd3:  r = (a < b) ? 32'd1 : 32'd0;
            4'd13: r = hi_m;
            4'd14: r = lo_m;
            default: r = '0;
        endcase
        return {v, r};
    endfunction

    task automatic ref_mdu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 4'd8) begin
            p = sa * sb;
            {eh, el} = p;
        end else if (op == 4'd9) begin
            pu = {32'd0, a} * {32'd0, b};
            {eh, el} = pu;
        end else if (b == 32'd0) begin
            el = '1;
            eh = a;
        end else if (op == 4'd10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            el = a;
            eh = '0;
        end else if (op == 4'd10) begin
            p = sa / sb;
            el = p[31:0];
            p = sa % sb;
            eh = p[31:0];
        end else begin
            el = a / b;
            eh = a % b;
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        bus.InValid = 1'b0;
        bus.Flush = 1'b0;
        bus.ALUControl = 4'd0;
        bus.A = '0;
        bus.B = '0;
        hi_m = '0;
        lo_m = '0;
        res_m = '0;
        #12;
        n_cmp++;
        if ({bus.ALUResult, bus.Zero, bus.Overflow, bus.OutValid, bus.Busy, bus.HI, bus.LO} !==
            {32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_state: res=%h z=%b ov=%b v=%b busy=%b hi=%h lo=%h",
                     bus.ALUResult, bus.Zero, bus.Overflow, bus.OutValid, bus.Busy, bus.HI, bus.LO);
        end
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        n_cmp++;
        if ({bus.InReady, bus.OutValid} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_ready: got ready=%b valid=%b expected 1 0", bus.InReady, bus.OutValid);
        end
    endtask

    task automatic test_alu_directed();
        logic [3:0]  ops [6] = '{4'd2, 4'd6, 4'd12, 4'd7, 4'd3, 4'd15};
        logic [31:0] as  [6] = '{32'h7FFF_FFFF, 32'd5, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [31:0] bs  [6] = '{32'd1, 32'd5, 32'h0F0F_0F00, 32'd1, 32'd1, 32'h9ABC_DEF0};
        logic [31:0] er  [6] = '{32'h8000_0000, 32'd0, 32'h0000_000F, 32'd1, 32'd0, 32'd0};
        logic        eo  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            bus.ALUControl = ops[i];
            bus.A = as[i];
            bus.B = bs[i];
            bus.InValid = 1'b1;
            @(posedge Clk); #1;
            bus.InValid = 1'b0;
            n_cmp++;
            if ({bus.OutValid, bus.Zero, bus.Overflow, bus.ALUResult} !== {1'b1, er[i] == 32'd0, eo[i], er[i]}) begin
                n_err++;
                $display("FAIL alu_directed op=%0d: got v=%b z=%b ov=%b res=%h expected v=1 z=%b ov=%b res=%h",
                         ops[i], bus.OutValid, bus.Zero, bus.Overflow, bus.ALUResult, er[i] == 32'd0, eo[i], er[i]);
            end
            res_m = er[i];
            @(posedge Clk); #1;
            n_cmp++;
            if (bus.OutValid !== 1'b0) begin
                n_err++;
                $display("FAIL alu_pulse op=%0d: got OutValid=%b expected 0", ops[i], bus.OutValid);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [3:0]  sc_ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd12, 4'd13, 4'd14, 4'd5, 4'd15};
        logic [31:0] picks  [6]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h8000_0001};
        logic [32:0] exp_v;
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 150; i++) begin
            op = sc_ops[$urandom_range(0, 11)];
            a = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 5)] : $urandom;
            exp_v = ref_alu(op, a, b);
            bus.ALUControl = op;
            bus.A = a;
            bus.B = b;
            bus.InValid = 1'b1;
            @(posedge Clk); #1;
            n_cmp++;
            if ({bus.OutValid, bus.Zero, bus.Overflow, bus.ALUResult} !==
                {1'b1, exp_v[31:0] == 32'd0, exp_v[32], exp_v[31:0]}) begin
                n_err++;
                $display("FAIL alu_random op=%0d a=%h b=%h: got v=%b z=%b ov=%b res=%h expected ov=%b res=%h",
                         op, a, b, bus.OutValid, bus.Zero, bus.Overflow, bus.ALUResult, exp_v[32], exp_v[31:0]);
            end
            res_m = exp_v[31:0];
        end
        bus.InValid = 1'b0;
        @(posedge Clk); #1;
        n_cmp++;
        if ({bus.OutValid, bus.ALUResult} !== {1'b0, res_m}) begin
            n_err++;
            $display("FAIL alu_random_idle: got v=%b res=%h expected v=0 res=%h", bus.OutValid, bus.ALUResult, res_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [3] = '{4'd0, 4'd1, 4'd4};
        logic [31:0] a, b;
        logic [32:0] exp_v;
        a = $urandom;
        b = $urandom;
        for (int i = 0; i < 3; i++) begin
            exp_v = ref_alu(ops[i], a, b);
            bus.ALUControl = ops[i];
            bus.A = a;
            bus.B = b;
            bus.InValid = 1'b1;
            @(posedge Clk); #1;
            n_cmp++;
            if ({bus.OutValid, bus.ALUResult} !== {1'b1, exp_v[31:0]}) begin
                n_err++;
                $display("FAIL back_to_back op=%0d: got v=%b res=%h expected v=1 res=%h",
                         ops[i], bus.OutValid, bus.ALUResult, exp_v[31:0]);
            end
            res_m = exp_v[31:0];
        end
        bus.InValid = 1'b0;
        @(posedge Clk); #1;
        n_cmp++;
        if (bus.OutValid !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_back_end: got OutValid=%b expected 0", bus.OutValid);
        end
    endtask

    task automatic test_mdu();
        logic [3:0]  ops [22];
        logic [31:0] as  [22];
        logic [31:0] bs  [22];
        logic [31:0] eh, el;
        logic [32:0] exp_v;
        logic        ready_bad, busy_bad;
        int          n;
        for (int i = 0; i < 16; i++) begin
            ops[i] = 4'd8 + 4'($urandom_range(0, 3));
            as[i]  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: bs[i] = 32'd0;
                1: bs[i] = 32'hFFFF_FFFF;
                2: bs[i] = 32'($urandom_range(1, 20));
                default: bs[i] = $urandom;
            endcase
        end
        ops[16] = 4'd8;  as[16] = 32'hFFFF_FFFD; bs[16] = 32'd7;
        ops[17] = 4'd9;  as[17] = 32'hFFFF_FFFD; bs[17] = 32'd7;
        ops[18] = 4'd10; as[18] = 32'hFFFF_FFF9; bs[18] = 32'd2;
        ops[19] = 4'd11; as[19] = 32'd5;         bs[19] = 32'd0;
        ops[20] = 4'd10; as[20] = 32'h8000_0000; bs[20] = 32'hFFFF_FFFF;
        ops[21] = 4'd9;  as[21] = 32'hFFFF_FFFF; bs[21] = 32'hFFFF_FFFF;
        for (int i = 0; i < 22; i++) begin
            ref_mdu(ops[i], as[i], bs[i], eh, el);
            bus.ALUControl = ops[i];
            bus.A = as[i];
            bus.B = bs[i];
            bus.InValid = 1'b1;
            @(posedge Clk); #1;
            bus.InValid = 1'b0;
            n = 0;
            ready_bad = 1'b0;
            busy_bad = 1'b0;
            while (bus.OutValid !== 1'b1 && n < 60) begin
                if (bus.InReady !== 1'b0) ready_bad = 1'b1;
                if (n <= 32 && bus.Busy !== 1'b1) busy_bad = 1'b1;
                @(posedge Clk); #1;
                n++;
            end
            n_cmp++;
            if (n !== 34) begin
                n_err++;
                $display("FAIL mdu_latency op=%0d: got %0d cycles expected 34", ops[i], n);
            end
            n_cmp++;
            if ({ready_bad, busy_bad} !== 2'b00) begin
                n_err++;
                $display("FAIL mdu_handshake op=%0d: got ready_seen=%b busy_dropped=%b expected 0 0",
                         ops[i], ready_bad, busy_bad);
            end
            n_cmp++;
            if ({bus.HI, bus.LO, bus.ALUResult, bus.Zero, bus.Overflow, bus.InReady} !==
                {eh, el, el, el == 32'd0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL mdu_result op=%0d a=%h b=%h: got hi=%h lo=%h res=%h z=%b ov=%b rdy=%b expected hi=%h lo=%h",
                         ops[i], as[i], bs[i], bus.HI, bus.LO, bus.ALUResult, bus.Zero, bus.Overflow, bus.InReady, eh, el);
            end
            hi_m = eh;
            lo_m = el;
            res_m = el;
        end
        for (int i = 0; i < 2; i++) begin
            bus.ALUControl = (i == 0) ? 4'd13 : 4'd14;
            exp_v = ref_alu(bus.ALUControl, 32'd0, 32'd0);
            bus.InValid = 1'b1;
            @(posedge Clk); #1;
            bus.InValid = 1'b0;
            n_cmp++;
            if ({bus.OutValid, bus.ALUResult} !== {1'b1, exp_v[31:0]}) begin
                n_err++;
                $display("FAIL mfhi_mflo op=%0d: got v=%b res=%h expected v=1 res=%h",
                         bus.ALUControl, bus.OutValid, bus.ALUResult, exp_v[31:0]);
            end
            res_m = exp_v[31:0];
        end
    endtask

    task automatic test_flush();
        logic seen_valid;
        bus.ALUControl = 4'd2;
        bus.A = $urandom;
        bus.B = $urandom;
        bus.InValid = 1'b1;
        bus.Flush = 1'b1;
        @(posedge Clk); #1;
        bus.InValid = 1'b0;
        bus.Flush = 1'b0;
        n_cmp++;
        if ({bus.OutValid, bus.ALUResult, bus.InReady} !== {1'b0, res_m, 1'b1}) begin
            n_err++;
            $display("FAIL flush_idle: got v=%b res=%h rdy=%b expected v=0 res=%h rdy=1",
                     bus.OutValid, bus.ALUResult, bus.InReady, res_m);
        end
        for (int k = 0; k < 2; k++) begin
            bus.ALUControl = 4'd8;
            bus.A = $urandom;
            bus.B = $urandom;
            bus.InValid = 1'b1;
            @(posedge Clk); #1;
            bus.InValid = 1'b0;
            // k=0 aborts mid-multiply, k=1 aborts in the final write cycle
            repeat ((k == 0) ? 10 : 33) @(posedge Clk);
            #1;
            bus.Flush = 1'b1;
            @(posedge Clk); #1;
            bus.Flush = 1'b0;
            n_cmp++;
            if ({bus.InReady, bus.OutValid, bus.Busy} !== 3'b100) begin
                n_err++;
                $display("FAIL flush_abort k=%0d: got rdy=%b v=%b busy=%b expected 1 0 0",
                         k, bus.InReady, bus.OutValid, bus.Busy);
            end
            seen_valid = 1'b0;
            repeat (40) begin
                @(posedge Clk); #1;
                if (bus.OutValid !== 1'b0) seen_valid = 1'b1;
            end
            n_cmp++;
            if ({seen_valid, bus.HI, bus.LO, bus.ALUResult} !== {1'b0, hi_m, lo_m, res_m}) begin
                n_err++;
                $display("FAIL flush_hold k=%0d: got pulse=%b hi=%h lo=%h res=%h expected pulse=0 hi=%h lo=%h res=%h",
                         k, seen_valid, bus.HI, bus.LO, bus.ALUResult, hi_m, lo_m, res_m);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.ALUControl = 4'd10;
        bus.A = $urandom;
        bus.B = $urandom;
        bus.InValid = 1'b1;
        @(posedge Clk); #1;
        bus.InValid = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        Rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ALUResult, bus.Zero, bus.Overflow, bus.OutValid, bus.Busy, bus.HI, bus.LO} !==
            {32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_mid: res=%h z=%b ov=%b v=%b busy=%b hi=%h lo=%h expected all cleared, z=1",
                     bus.ALUResult, bus.Zero, bus.Overflow, bus.OutValid, bus.Busy, bus.HI, bus.LO);
        end
        #1;
        Rst_n = 1'b1;
        hi_m = '0;
        lo_m = '0;
        res_m = '0;
        @(posedge Clk); #1;
        n_cmp++;
        if ({bus.InReady, bus.OutValid, bus.Busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_mid_release: got rdy=%b v=%b busy=%b expected 1 0 0",
                     bus.InReady, bus.OutValid, bus.Busy);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_back_to_back();
        test_mdu();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
